// File: rtl/n64_si_pif_dma_pkg.sv
// n64_pif_pkg: shared states and constants for the PIF RAM host-side DMA sequencer
package n64_pif_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_OUT, WR, DONE} state_t;
    localparam logic [8:0] PIF_RAM_BASE_WORD = 9'h1F0;
    localparam int PIF_BLOCK_WORDS = 16;
    localparam logic DIR_READ = 1'b0;
    localparam logic DIR_WRITE = 1'b1;
endpackage

// File: rtl/n64_si_pif_dma_if.sv
// n64_si_pif_dma_if: control, PIF RAM port-B and read/write stream signals
// master: the sequencer (drives busy/done, RAM address/write, rd stream, wr_ready)
// slave: the environment (drives start/dir, RAM read data, rd_ready, wr stream)
interface n64_si_pif_dma_if;
    logic        start;
    logic        dir;
    logic        busy;
    logic        done;
    logic [8:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    modport master (
        input  start, dir, ram_rdata, rd_ready, wr_data, wr_valid,
        output busy, done, ram_addr, ram_wren, ram_wdata, rd_data, rd_valid, wr_ready
    );
    modport slave (
        output start, dir, ram_rdata, rd_ready, wr_data, wr_valid,
        input  busy, done, ram_addr, ram_wren, ram_wdata, rd_data, rd_valid, wr_ready
    );
endinterface

// File: rtl/n64_si_pif_dma.sv
// n64_si_pif_dma: moves the PIF RAM command block between port B and the SI DMA streams
// clk/reset: single clock, synchronous active-high reset
// bus: start/dir in, busy/done out, port-B RAM bus, rd stream out, wr stream in
module n64_si_pif_dma
    import n64_pif_pkg::*;
#(
    parameter logic [8:0] BASE_WORD = PIF_RAM_BASE_WORD,
    parameter int         WORDS     = PIF_BLOCK_WORDS
) (
    input logic              clk,
    input logic              reset,
    n64_si_pif_dma_if.master bus
);
    localparam int CW = $clog2(WORDS);
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_valid;
    logic            r_wr_ready;
    logic            w_last;
    assign w_last        = r_cnt == CW'(WORDS - 1);
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.wr_ready  = r_wr_ready;
    assign bus.ram_addr  = BASE_WORD + 9'(r_cnt);
    assign bus.ram_wdata = bus.wr_data;
    // reset blocks a write in the aborting cycle so no word lands after the abort edge
    assign bus.ram_wren  = r_wr_ready & bus.wr_valid & ~reset;
    // address is held through RD_OUT, so the RAM's registered output is the beat data
    assign bus.rd_data   = r_rd_valid ? bus.ram_rdata : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state    <= (bus.dir == DIR_WRITE) ? WR : RD_ADDR;
                    r_wr_ready <= bus.dir == DIR_WRITE;
                    r_cnt      <= '0;
                    r_busy     <= 1'b1;
                end
                RD_ADDR: begin
                    r_state    <= RD_OUT;
                    r_rd_valid <= 1'b1;
                end
                RD_OUT: if (bus.rd_ready) begin
                    r_rd_valid <= 1'b0;
                    r_state    <= w_last ? DONE : RD_ADDR;
                    r_done     <= w_last;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                WR: if (bus.wr_valid) begin
                    r_wr_ready <= !w_last;
                    r_state    <= w_last ? DONE : WR;
                    r_done     <= w_last;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_n64_si_pif_dma.sv
// tb_n64_si_pif_dma: directed checks of the PIF RAM DMA sequencer against a port-B RAM model
module tb_n64_si_pif_dma;
    import n64_pif_pkg::*;
    logic        clk;
    logic        reset;
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [512];
    int          total;
    int          bad;
    n64_si_pif_dma_if bus ();
    n64_si_pif_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // port B with one-cycle registered read; pre_* models the PIF side filling the RAM
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic preload(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = 9'h1F0 + 9'(i);
            pre_data = base + 32'(i);
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
    endtask
    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
        chk({tag, "_ram_wren"}, 32'(bus.ram_wren), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h1F0);
        chk({tag, "_rd_data"}, bus.rd_data, 32'd0);
    endtask
    task automatic do_read(input logic toggle, input logic poke);
        int beats = 0, done_cyc = 0, done_n = 0, busy_n = 0, wren_n = 0;
        logic stall = 1'b0;
        logic [31:0] pd = '0;
        logic [8:0] pa = '0;
        bus.start = 1'b1;
        bus.dir   = DIR_READ;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            bus.rd_ready = toggle ? c[0] : 1'b1;
            if (poke) begin
                bus.start = (c == 5 || c == 33);
                bus.dir   = (c == 5 || c == 33) ? DIR_WRITE : DIR_READ;
            end
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_cyc = c;
            end
            if (bus.ram_wren) wren_n++;
            if (stall && bus.rd_valid) begin
                chk("rd_hold_data", bus.rd_data, pd);
                chk("rd_hold_addr", 32'(bus.ram_addr), 32'(pa));
            end
            stall = bus.rd_valid && !bus.rd_ready;
            pd    = bus.rd_data;
            pa    = bus.ram_addr;
            if (bus.rd_valid && bus.rd_ready) begin
                chk("rd_data", bus.rd_data, 32'hA000_0000 + 32'(beats));
                chk("rd_addr", 32'(bus.ram_addr), 32'h1F0 + 32'(beats));
                beats++;
            end
            @(posedge clk);
            #1;
            if (done_cyc != 0 && c > done_cyc) break;
        end
        bus.start    = 1'b0;
        bus.rd_ready = 1'b0;
        chk("rd_finished", 32'(done_cyc != 0), 32'd1);
        chk("rd_beats", 32'(beats), 32'd16);
        chk("rd_done_pulses", 32'(done_n), 32'd1);
        chk("rd_no_wren", 32'(wren_n), 32'd0);
        chk("rd_busy_cycles", 32'(busy_n), 32'(done_cyc));
        if (!toggle) chk("rd_done_cycle", 32'(done_cyc), 32'd33);
        @(negedge clk);
        chk("rd_idle_after", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic do_write(input int gap, input logic [31:0] dbase, input int abort);
        int nw = 0, last = 0, done_cyc = 0, done_n = 0, busy_n = 0, bad_wren = 0;
        bus.start = 1'b1;
        bus.dir   = DIR_WRITE;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            bus.wr_valid = (c % gap) == 0;
            bus.wr_data  = dbase + 32'(nw);
            if (abort != 0 && nw == abort) reset = 1'b1;
            @(negedge clk);
            if (c == 1) chk("wr_ready", 32'(bus.wr_ready), 32'd1);
            if (reset) chk("abort_wren", 32'(bus.ram_wren), 32'd0);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_cyc = c;
            end
            if (bus.ram_wren) begin
                if (!bus.wr_valid) bad_wren++;
                chk("wr_addr", 32'(bus.ram_addr), 32'h1F0 + 32'(nw));
                chk("wr_wdata", bus.ram_wdata, dbase + 32'(nw));
                nw++;
                last = c;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                break;
            end
            if (done_cyc != 0 && c > done_cyc) break;
        end
        bus.wr_valid = 1'b0;
        chk("wr_no_stray_wren", 32'(bad_wren), 32'd0);
        if (abort == 0) begin
            chk("wr_count", 32'(nw), 32'd16);
            chk("wr_done_pulses", 32'(done_n), 32'd1);
            chk("wr_done_cycle", 32'(done_cyc), 32'(last + 1));
            chk("wr_busy_cycles", 32'(busy_n), 32'(done_cyc));
            for (int i = 0; i < 16; i++) chk("wr_readback", mem[9'h1F0 + 9'(i)], dbase + 32'(i));
        end else begin
            @(negedge clk);
            check_idle("abort");
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.done) done_n++;
            end
            chk("abort_count", 32'(nw), 32'(abort));
            chk("abort_no_done", 32'(done_n), 32'd0);
            for (int i = 0; i < 16; i++)
                chk("abort_mem", mem[9'h1F0 + 9'(i)], (i < abort) ? dbase + 32'(i) : 32'hDEAD_0000 + 32'(i));
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus.start = 1'b0;
        bus.dir = DIR_READ;
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        @(posedge clk);
        #1;
        preload(32'hA000_0000);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("idle_wren_ignored", 32'(bus.ram_wren), 32'd0);
        chk("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        do_read(1'b0, 1'b0);
        do_write(1, 32'h1111_0000, 0);
        preload(32'hA000_0000);
        do_read(1'b1, 1'b0);
        do_write(3, 32'h2222_0000, 0);
        preload(32'hA000_0000);
        do_read(1'b0, 1'b1);
        do_write(1, 32'h4444_0000, 0);
        preload(32'hDEAD_0000);
        do_write(1, 32'h3333_0000, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
